// File: rtl/fifo_burst_reader_pkg.sv
// rtl/fifo_burst_reader_pkg.sv - state encoding and timing constants shared by the burst reader
package fifo_burst_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_ARM    = 3'd2,
        ST_BURST  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_FIN    = 3'd6
    } state_t;

    localparam int SETTLE_CYCLES = 2;
    localparam int FLUSH_CYCLES  = 2;
    localparam int RD_LAT        = 1;

endpackage

// File: rtl/fifo_burst_reader_burst_out_buf.sv
// rtl/fifo_burst_reader_burst_out_buf.sv - 2-entry register buffer between FIFO read data and the output stream
module burst_out_buf #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    logic [DATA_W-1:0] data0, data1;
    logic              last0, last1;
    logic [1:0]        occ_q;

    // Slot 0 is always the head; slot 1 only holds a word while slot 0 is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        data0 <= push_data;
                        last0 <= push_last;
                        occ_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        data0 <= push_data;
                        last0 <= push_last;
                    end else if (push) begin
                        data1 <= push_data;
                        last1 <= push_last;
                        occ_q <= 2'd2;
                    end else if (pop) begin
                        occ_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        data0 <= data1;
                        last0 <= last1;
                        if (push) begin
                            data1 <= push_data;
                            last1 <= push_last;
                        end else begin
                            occ_q <= 2'd1;
                        end
                    end
                end
                default: occ_q <= 2'd0;
            endcase
        end
    end

    assign occ        = occ_q;
    assign head_valid = (occ_q != 2'd0);
    assign head_data  = data0;
    assign head_last  = head_valid && last0;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - threshold-armed burst reader from the width-converting FIFO; BURST_READER_PERF_EN adds a stall counter
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_BITS = 10,
    parameter int TOT_BITS  = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TOT_BITS-1:0]  total_words,
    input  logic [ADDR_BITS:0]   burst_len,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_flush,
    output logic [ADDR_BITS:0]   fifo_m_count,
    input  logic                 fifo_m_ready,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_W-1:0]    fifo_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    output logic                 err_underflow
`ifdef BURST_READER_PERF_EN
    ,
    output logic [31:0]          perf_stall_cycles
`endif
);

    localparam int CW = ADDR_BITS + 1;
    localparam int MW = (TOT_BITS > CW) ? TOT_BITS : CW;

    state_t              state, state_nx;
    logic [1:0]          phase_cnt;
    logic [TOT_BITS-1:0] remaining;
    logic [CW-1:0]       burst_reg, burst_cnt, mc_next;
    logic [MW-1:0]       rem_w, brl_w;
    logic [RD_LAT-1:0]   rd_pipe, last_pipe;
    logic                inflight, inflight_last;
    logic [1:0]          occ;
    logic [2:0]          fill_nx;
    logic                pop, space, start_acc, rd_last;

    assign start_acc     = (state == ST_IDLE) && start;
    assign inflight      = rd_pipe[RD_LAT-1];
    assign inflight_last = last_pipe[RD_LAT-1];
    assign pop           = m_valid && m_ready;
    // Occupancy the buffer will hold next cycle if nothing new is requested now.
    assign fill_nx       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign space         = (fill_nx < 3'd2);
    assign rd_last       = (remaining == TOT_BITS'(1));

    assign rem_w   = MW'(remaining);
    assign brl_w   = MW'(burst_reg);
    assign mc_next = CW'((rem_w < brl_w) ? rem_w : brl_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (start) state_nx = (total_words == '0) ? ST_FIN : ST_FLUSH;
            ST_FLUSH:  if (phase_cnt == 2'(FLUSH_CYCLES - 1)) state_nx = ST_ARM;
            ST_ARM:    if (fifo_m_ready) state_nx = ST_BURST;
            ST_BURST:  if (fifo_rd_en && burst_cnt == CW'(1))
                           state_nx = (remaining > TOT_BITS'(1)) ? ST_SETTLE : ST_DRAIN;
            ST_SETTLE: if (phase_cnt == 2'(SETTLE_CYCLES - 1)) state_nx = ST_ARM;
            ST_DRAIN:  if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) state_nx = ST_FIN;
            ST_FIN:    state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE) && (state != ST_FIN);
        done       = (state == ST_FIN);
        fifo_flush = (state == ST_FLUSH) && (phase_cnt == 2'd0);
        fifo_rd_en = (state == ST_BURST) && (burst_cnt != '0) && !fifo_empty && space;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt     <= 2'd0;
            remaining     <= '0;
            burst_reg     <= '0;
            burst_cnt     <= '0;
            fifo_m_count  <= '0;
            rd_pipe       <= '0;
            last_pipe     <= '0;
            err_underflow <= 1'b0;
        end else begin
            phase_cnt <= (state_nx != state) ? 2'd0 : phase_cnt + 2'd1;
            rd_pipe   <= RD_LAT'({rd_pipe, fifo_rd_en});
            last_pipe <= RD_LAT'({last_pipe, fifo_rd_en && rd_last});

            if (start_acc) begin
                remaining     <= total_words;
                burst_reg     <= (burst_len == '0) ? CW'(1) : burst_len;
                err_underflow <= 1'b0;
            end else if (fifo_rd_en && remaining != '0) begin
                remaining <= remaining - 1'b1;
            end

            if (state == ST_ARM && fifo_m_ready) begin
                burst_cnt <= fifo_m_count;
            end else if (fifo_rd_en) begin
                burst_cnt <= burst_cnt - 1'b1;
            end

            // Threshold is only refreshed on ARM entry so the FIFO sees it stable through BURST.
            if (state_nx == ST_ARM && state != ST_ARM) begin
                fifo_m_count <= mc_next;
            end

            if (state == ST_BURST && burst_cnt != '0 && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    burst_out_buf #(
        .DATA_W(DATA_W)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (fifo_dout),
        .push_last  (inflight_last),
        .pop        (pop),
        .occ        (occ),
        .head_valid (m_valid),
        .head_data  (m_data),
        .head_last  (m_last)
    );

`ifdef BURST_READER_PERF_EN
    logic stall;
    assign stall = ((state == ST_ARM) && !fifo_m_ready) ||
                   ((state == ST_BURST) && (burst_cnt != '0) && !space);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
        end else if (start_acc) begin
            perf_stall_cycles <= '0;
        end else if (stall && perf_stall_cycles != '1) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - randomized scoreboard bench for fifo_burst_reader with a behavioural FIFO model
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DATA_W    = 128;
    localparam int ADDR_BITS = 10;
    localparam int TOT_BITS  = 24;
    localparam int CW        = ADDR_BITS + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [TOT_BITS-1:0] total_words = '0;
    logic [CW-1:0]       burst_len = '0;
    logic                busy, done, fifo_flush, fifo_rd_en, m_valid, m_last, err_underflow;
    logic [CW-1:0]       fifo_m_count;
    logic                fifo_m_ready = 1'b0;
    logic                fifo_empty;
    logic                fifo_empty_r = 1'b1;
    logic [DATA_W-1:0]   fifo_dout = '0;
    logic [DATA_W-1:0]   m_data;
    logic                m_ready = 1'b0;
`ifdef BURST_READER_PERF_EN
    logic [31:0]         perf_stall_cycles;
`endif

    fifo_burst_reader #(
        .DATA_W(DATA_W), .ADDR_BITS(ADDR_BITS), .TOT_BITS(TOT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .total_words(total_words), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_flush(fifo_flush), .fifo_m_count(fifo_m_count),
        .fifo_m_ready(fifo_m_ready), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .err_underflow(err_underflow)
`ifdef BURST_READER_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } word_t;

    word_t             sb_q[$];
    logic [DATA_W-1:0] fq[$];
    int                exp_mc[$];
    int                obs_mc[$];

    int checks = 0, failures = 0;
    int cyc = 0;
    int mr_pct = 100;
    bit hold_mr_low = 1'b0, force_empty = 1'b0;

    int rd_total = 0, hs_total = 0, flush_total = 0, done_total = 0, viol_total = 0;
    int out_cnt = 0, burst_rd = 0, burst_mc = 0, last_rd_cyc = 0, last_hs_cyc = 0, start_cyc = 0;
    bit first_burst = 1'b0, zero_job = 1'b0;
    word_t mon_w;

    assign fifo_empty = force_empty || fifo_empty_r;

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural FIFO: 1-cycle read latency, registered empty and M_Ready.
    initial forever begin
        @(posedge clk);
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        fifo_empty_r <= (fq.size() == 0);
        fifo_m_ready <= !hold_mr_low && (fq.size() >= int'(fifo_m_count));
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(0, 99) < mr_pct);
    end

    // Monitor: pops the scoreboard on handshakes and tracks protocol rules.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            out_cnt  = 0;
            burst_rd = 0;
        end else begin
            if (start && !busy) begin
                start_cyc   = cyc;
                zero_job    = (total_words == '0);
                first_burst = 1'b1;
                burst_rd    = 0;
                obs_mc.delete();
            end
            if (out_cnt > 2) viol_total++;
            if (fifo_rd_en && fifo_empty) viol_total++;
            if (fifo_rd_en) begin
                rd_total++;
                if (burst_rd == 0) begin
                    burst_mc = int'(fifo_m_count);
                    if (!first_burst && (cyc - last_rd_cyc) < 4) viol_total++;
                    first_burst = 1'b0;
                end
                burst_rd++;
                if (burst_rd == burst_mc) begin
                    obs_mc.push_back(burst_mc);
                    burst_rd = 0;
                end
                last_rd_cyc = cyc;
            end
            if (fifo_flush) flush_total++;
            if (m_valid && m_ready) begin
                hs_total++;
                last_hs_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk(1'b0, "extra_word", m_data, 0);
                end else begin
                    mon_w = sb_q.pop_front();
                    chk(m_data == mon_w.d, "word_data", m_data, mon_w.d);
                    chk(m_last == mon_w.last, "word_last", m_last, mon_w.last);
                end
            end
            out_cnt += (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (done) begin
                done_total++;
                chk(cyc == (zero_job ? start_cyc + 1 : last_hs_cyc + 1), "done_timing",
                    cyc, zero_job ? start_cyc + 1 : last_hs_cyc + 1);
                chk(busy == 1'b0, "busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic chk_idle(input string nm);
        chk({busy, done, fifo_flush, fifo_rd_en, m_valid, m_last, err_underflow} == 7'b0, nm,
            {busy, done, fifo_flush, fifo_rd_en, m_valid, m_last, err_underflow}, 0);
        chk(fifo_m_count == '0, {nm, "_mcount"}, fifo_m_count, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_q.delete();
        fq.delete();
        rst = 1'b0;
    endtask

    task automatic load_job(input int total, input int blen);
        int b, rem, n;
        word_t w;
        exp_mc.delete();
        b   = (blen == 0) ? 1 : blen;
        rem = total;
        while (rem > 0) begin
            n = (rem < b) ? rem : b;
            exp_mc.push_back(n);
            rem -= n;
        end
        for (int i = 0; i < total; i++) begin
            w.d    = {$urandom, $urandom, $urandom, $urandom};
            w.last = (i == total - 1);
            fq.push_back(w.d);
            sb_q.push_back(w);
        end
    endtask

    task automatic run_job(input int total, input int blen, input int pct, input int hold_mr, input int uf_at);
        int base_rd, base_fl, base_v, base_done, t;
        mr_pct = pct;
        load_job(total, blen);
        @(posedge clk); #1;
        base_rd = rd_total; base_fl = flush_total; base_v = viol_total; base_done = done_total;
        hold_mr_low = (hold_mr > 0);
        total_words = TOT_BITS'(total);
        burst_len   = CW'(blen);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (total > 0) chk(busy == 1'b1, "busy_after_start", busy, 1);
        chk(err_underflow == 1'b0, "err_cleared_on_start", err_underflow, 0);
        if (hold_mr > 0) begin
            repeat (hold_mr) @(negedge clk);
            chk(rd_total == base_rd, "no_rd_while_mready_low", rd_total - base_rd, 0);
`ifdef BURST_READER_PERF_EN
            chk(perf_stall_cycles >= 32'd20, "perf_stall_cycles", perf_stall_cycles, 20);
`endif
            hold_mr_low = 1'b0;
        end
        if (uf_at > 0) begin
            t = 0;
            do begin
                @(posedge clk); #1;
                t++;
            end while ((rd_total - base_rd) < uf_at && t < 2000);
            force_empty = 1'b1;
            repeat (10) @(negedge clk);
            chk(err_underflow == 1'b1, "err_underflow_set", err_underflow, 1);
            chk((rd_total - base_rd) == uf_at, "no_rd_while_empty", rd_total - base_rd, uf_at);
            @(posedge clk); #1;
            force_empty = 1'b0;
        end
        t = 0;
        while (done_total == base_done && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(done_total > base_done, "done_timeout", done_total - base_done, 1);
        if (done_total == base_done) begin
            do_reset();
        end else begin
            chk((rd_total - base_rd) == total, "rd_count", rd_total - base_rd, total);
            chk((flush_total - base_fl) == ((total > 0) ? 1 : 0), "flush_count",
                flush_total - base_fl, (total > 0) ? 1 : 0);
            chk(sb_q.size() == 0, "words_undelivered", sb_q.size(), 0);
            chk(obs_mc.size() == exp_mc.size(), "burst_count", obs_mc.size(), exp_mc.size());
            if (obs_mc.size() == exp_mc.size())
                foreach (exp_mc[i]) chk(obs_mc[i] == exp_mc[i], "m_count_seq", obs_mc[i], exp_mc[i]);
            chk(viol_total == base_v, "protocol_violations", viol_total - base_v, 0);
            chk(err_underflow == (uf_at > 0), "err_underflow_end", err_underflow, uf_at > 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_burst();
        int base_rd, base_done, t;
        mr_pct = 50;
        load_job(16, 8);
        @(posedge clk); #1;
        base_rd = rd_total;
        total_words = TOT_BITS'(16);
        burst_len   = CW'(8);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while ((rd_total - base_rd) < 3 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk((rd_total - base_rd) >= 3, "reached_burst_before_rst", rd_total - base_rd, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("outputs_after_mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        fq.delete();
        base_done = done_total;
        repeat (12) @(posedge clk);
        #1;
        chk(done_total == base_done, "no_done_after_rst", done_total - base_done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        run_job(8, 4, 100, 0, 0);
        run_job(10, 4, 100, 0, 0);
        run_job(16, 8, 50, 0, 0);
        run_job(8, 4, 100, 25, 0);
        run_job(8, 8, 100, 0, 5);
        run_job(3, 2, 100, 0, 0);
        run_job(0, 4, 100, 0, 0);
        run_job(1, 0, 100, 0, 0);
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(1, 40), $urandom_range(0, 9), $urandom_range(20, 100), 0, 0);
        reset_mid_burst();
        run_job(5, 3, 70, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
